// File: rtl/instr_encoder_pkg.sv
// Shared RV32 encoding constants and types for the instruction assembler
// and the immediate extender.
package instr_encoder_pkg;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_R = 2'b11
   } imm_src_e;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_REG    = 7'h33;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } enc_word_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32 field packer with immediate range check; out-of-range
// immediates are still packed with truncated bits.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [1:0]  imm_src,
   input  logic [31:0] imm,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [6:0]  funct7,
   output logic [31:0] instr,
   output logic        err
);

   logic fits12;
   logic fits13;

   // Sign-extension test: upper bits all equal to the sign of the field
   assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
   assign fits13 = (&imm[31:12]) || !(|imm[31:12]);

   always_comb begin
      instr = '0;
      err   = 1'b0;
      unique case (imm_src_e'(imm_src))
         IMM_I: begin
            instr = {imm[11:0], rs1, funct3, rd, opcode};
            err   = !fits12;
         end
         IMM_S: begin
            instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            err   = !fits12;
         end
         IMM_B: begin
            instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            err   = !fits13 || imm[0];
         end
         IMM_R: begin
            instr = {funct7, rs2, rs1, funct3, rd, opcode};
            err   = 1'b0;
         end
         default: begin
            instr = '0;
            err   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32 instruction assembler: packs fields into words, queues them
// in a small FIFO with valid/ready handshakes and keeps saturating statistics.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       imm_src,
   input  logic [31:0]      imm,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [2:0]       funct3,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [6:0]       funct7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   enc_word_t        mem [DEPTH];
   enc_word_t        packed_word;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;
   logic             push;
   logic             pop;

   instr_pack u_pack (
      .imm_src (imm_src),
      .imm     (imm),
      .opcode  (opcode),
      .rd      (rd),
      .funct3  (funct3),
      .rs1     (rs1),
      .rs2     (rs2),
      .funct7  (funct7),
      .instr   (packed_word.instr),
      .err     (packed_word.err)
   );

   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = (count != '0);
   assign out_instr = out_valid ? mem[rd_ptr].instr : '0;
   assign out_err   = out_valid ? mem[rd_ptr].err : 1'b0;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + (PTR_W+1)'(1);
      else if (pop && !push)
         count_next = count - (PTR_W+1)'(1);
   end

   // in_ready is a flop of the next occupancy, so out_ready never reaches it combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= packed_word;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count_next;
         in_ready <= (count_next != (PTR_W+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (clr_cnt) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (push) begin
         if (enc_count != '1)
            enc_count <= enc_count + CNT_W'(1);
         if (packed_word.err && (err_count != '1))
            err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed encodings and a
// small queue model for the backpressure/wrap phase.
module tb_instr_encoder;

   localparam int DEPTH = 2;
   localparam int CNT_W = 4;
   localparam int MAXC  = 15;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       imm_src;
   logic [31:0]      imm;
   logic [6:0]       opcode;
   logic [4:0]       rd;
   logic [2:0]       funct3;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [6:0]       funct7;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_err;
   logic             clr_cnt;
   logic [CNT_W-1:0] enc_count;
   logic [CNT_W-1:0] err_count;

   int vectors;
   int miscompares;
   int enc_exp;
   int err_exp;

   instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm_src   (imm_src),
      .imm       (imm),
      .opcode    (opcode),
      .rd        (rd),
      .funct3    (funct3),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct7    (funct7),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .clr_cnt   (clr_cnt),
      .enc_count (enc_count),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic set_fields(input logic [1:0] s, input logic [31:0] i, input logic [6:0] op,
                             input logic [4:0] d, input logic [2:0] f3, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [6:0] f7);
      imm_src = s; imm = i; opcode = op; rd = d; funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7;
   endtask

   // Called at a negedge with an empty FIFO; one word in, checked, then drained
   task automatic send(input string tag, input logic [1:0] s, input logic [31:0] i,
                       input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
                       input logic [31:0] exp_instr, input logic exp_err);
      set_fields(s, i, op, d, f3, r1, r2, f7);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      if (enc_exp != MAXC) enc_exp++;
      if (exp_err && err_exp != MAXC) err_exp++;
      in_valid = 1'b0;
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_instr"}, out_instr, exp_instr);
      check_eq({tag, "_err"}, 32'(out_err), 32'(exp_err));
      check_eq({tag, "_enc"}, 32'(enc_count), 32'(enc_exp));
      @(negedge clk);
      check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int          q[$];
      int          k;
      logic        push_m;
      logic        pop_m;
      logic [31:0] word_exp;

      vectors = 0; miscompares = 0; enc_exp = 0; err_exp = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
      set_fields(2'b00, '0, '0, '0, '0, '0, '0, '0);

      repeat (3) @(negedge clk);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_instr", out_instr, 32'd0);
      check_eq("rst_err", 32'(out_err), 32'd0);
      check_eq("rst_enc", 32'(enc_count), 32'd0);
      check_eq("rst_errcnt", 32'(err_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_inrdy", 32'(in_ready), 32'd1);

      send("addi", 2'b00, 32'hFFFF_FFFF, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFF00093, 1'b0);
      send("sw",   2'b01, 32'd8,         7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'h0020A423, 1'b0);
      send("beq",  2'b10, -32'sd4,       7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFE208EE3, 1'b0);
      send("add",  2'b11, 32'h1234_5678, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h002081B3, 1'b0);
      send("i_ovf", 2'b00, 32'd2048,     7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h80000093, 1'b1);
      send("b_odd", 2'b10, 32'd3,        7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'h00208163, 1'b1);
      check_eq("errcnt2", 32'(err_count), 32'd2);
      send("i_min", 2'b00, -32'sd2048,   7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h80000093, 1'b0);
      check_eq("errcnt_keep", 32'(err_count), 32'd2);

      // Backpressure then streaming across pointer wrap, checked against a queue model
      k = 1;
      set_fields(2'b00, 32'(k), 7'h13, 5'(k), 3'd0, 5'd0, 5'd0, 7'd0);
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         out_ready = (cyc >= 4);
         check_eq("st_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) check_eq("st_head", out_instr, q[0]);
         check_eq("st_inrdy", 32'(in_ready), 32'(q.size() < DEPTH));
         push_m = (q.size() < DEPTH);
         pop_m  = (q.size() != 0) && out_ready;
         @(negedge clk);
         if (pop_m) void'(q.pop_front());
         if (push_m) begin
            word_exp = {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
            q.push_back(word_exp);
            if (enc_exp != MAXC) enc_exp++;
            k++;
            set_fields(2'b00, 32'(k), 7'h13, 5'(k), 3'd0, 5'd0, 5'd0, 7'd0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("st_drained", 32'(out_valid), 32'd0);
      check_eq("enc_sat", 32'(enc_count), 32'(enc_exp));
      check_eq("enc_sat15", 32'(enc_count), 32'd15);

      // clr_cnt wins over a simultaneous push
      set_fields(2'b00, 32'd2048, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0);
      in_valid = 1'b1;
      clr_cnt  = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      check_eq("clr_enc", 32'(enc_count), 32'd0);
      check_eq("clr_err", 32'(err_count), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("post_clr_enc", 32'(enc_count), 32'd1);
      check_eq("post_clr_err", 32'(err_count), 32'd1);
      repeat (2) @(negedge clk);

      // Reset with two words buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      check_eq("pre_rst_full", 32'(in_ready), 32'd0);
      check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_instr", out_instr, 32'd0);
      check_eq("mid_rst_enc", 32'(enc_count), 32'd0);
      check_eq("mid_rst_err", 32'(err_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_inrdy", 32'(in_ready), 32'd1);
      check_eq("post_rst_valid", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32 instruction assembler, the inverse of the immediate extender. Accepts decoded fields plus a 32-bit immediate and a 2-bit immediate-format selector, and packs them into a 32-bit instruction word. Words are buffered in a small FIFO with a valid/ready handshake toward the instruction-memory loader or bench. The block range-checks immediates and keeps accept/error counters.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept this cycle
imm_src  input  2  00 I-type, 01 S-type, 10 B-type, 11 R-type (no immediate)
imm  input  32  immediate value, two's complement
opcode  input  7  instr[6:0]
rd  input  5  instr[11:7]; ignored for S and B
funct3  input  3  instr[14:12]
rs1  input  5  instr[19:15]
rs2  input  5  instr[24:20]; ignored for I
funct7  input  7  instr[31:25]; used for R only
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head this cycle
out_instr  output  32  encoded instruction at FIFO head
out_err  output  1  immediate of the head word was out of range
clr_cnt  input  1  synchronous clear of both counters
enc_count  output  CNT_W  accepted inputs, saturating
err_count  output  CNT_W  accepted inputs with err, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. in_ready is 1 one cycle after reset release.
- Reset mid-operation: buffered words are discarded and the counters are zeroed.
- Encoding (combinational, before FIFO write):
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; imm is ignored.
- Range check:
  - I/S: err=1 unless imm[31:11] is all equal, i.e. -2048..2047.
  - B: err=1 unless imm[31:12] is all equal and imm[0]=0.
  - R: err=0.
  - An erroring word is still encoded with truncated bits and is still enqueued. err travels with the word.
- Handshake:
  - Input transfer on in_valid&&in_ready. Output transfer on out_valid&&out_ready.
  - in_ready = !full, registered from occupancy with no combinational path from out_ready.
  - out_instr and out_err must stay stable while out_valid&&!out_ready.
- Latency: a word accepted at edge N is visible on out_valid/out_instr after edge N. One cycle when empty; no bypass.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits plus an occupancy counter 0..DEPTH. Pointers wrap modulo DEPTH.
  - Simultaneous push and pop with occupancy between 1 and DEPTH-1: occupancy unchanged and both pointers advance.
  - Full: in_ready=0 and no push occurs, even if out_ready=1 that cycle.
  - Empty: out_valid=0; out_ready is ignored.
- Counters:
  - enc_count increments on every input transfer. err_count increments on every input transfer with err=1.
  - Both saturate at 2^CNT_W-1.
  - clr_cnt has priority over an increment in the same cycle (result 0).

Decomposition:
- Shared package holds:
  - imm_src codes IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_R=2'b11, shared with the immediate extender.
  - Opcode constants OP_IMM=7'h13, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_REG=7'h33.
- One sub-module, instr_pack: purely combinational field packing plus range check, giving {instr, err}. The FIFO and counters stay in instr_encoder.

Test Plan:
- I-type, addi x1,x0,-1: imm=32'hFFFFFFFF, rd=1, rs1=0, f3=0, op=13h -> out_instr=32'hFFF00093, err=0, one cycle latency, enc_count=1.
- S-type, sw x2,8(x1): imm=8, rs1=1, rs2=2, f3=2, op=23h -> 32'h0020A423, err=0.
- B-type and R-type:
  - beq x1,x2,-4: imm=-4, rs1=1, rs2=2, op=63h -> 32'hFE208EE3.
  - add x3,x1,x2: imm_src=11, f7=0, op=33h -> 32'h002081B3.
- Errors:
  - I-type imm=2048 -> err=1, instr[31:20]=12'h800.
  - B-type imm=3 -> err=1.
  - err_count=2 after both.
- Backpressure: out_ready=0, push 3 words back-to-back -> in_ready falls after the 2nd, 3rd held off; head stable. Then out_ready=1 with continuous in_valid -> order preserved across pointer wrap, occupancy steady.
- Reset and counters:
  - Assert rst_n=0 with 2 words buffered -> out_valid=0 immediately, counters 0.
  - Force enc_count to 2^CNT_W-1 -> stays saturated on further pushes.
  - clr_cnt together with a push -> count 0.
